divider_arbiter: RTL

- Shares one Fixed_Point_Divider_Top instance between NREQ requesters.
- Arbitrates requests round-robin, sequences the divider's start/complete protocol and returns the quotient tagged with the requester ID.
- Short-circuits divide-by-zero and aborts a hung divider on timeout.
- Operands and results are sign-magnitude, N bits, Q fractional bits: bit N-1 is the sign, bits N-2:0 are the magnitude.

---
 rtl/divider_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Shares one fixed-point divider between NREQ requesters. Grants round-robin,
// runs the divider start/complete handshake, short-circuits divide-by-zero,
// aborts a hung divider after TIMEOUT_CYC cycles and returns a tagged result.
module divider_arbiter #(
    parameter int N           = 32,
    parameter int Q           = 3,
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_quotient,
    output logic [1:0]        rsp_err,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    output logic              div_start,
    input  logic [N-1:0]      div_quotient,
    input  logic              div_complete,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Q only travels to the divider; it is checked here so a bad pairing fails elaboration.
    if (IDW != $clog2(NREQ) || Q >= N) begin : g_param_check
        $fatal(1, "divider_arbiter: IDW must be clog2(NREQ) and Q must be below N");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic [IDW-1:0]    rsp_id_q;
    logic [N-1:0]      rsp_quotient_q;
    logic [1:0]        rsp_err_q;
    logic [N-1:0]      div_dividend_q;
    logic [N-1:0]      div_divisor_q;

    logic [N-1:0]      dvd_arr [NREQ];
    logic [N-1:0]      dvs_arr [NREQ];
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand_idx;
    logic [N-1:0]      sel_dvd;
    logic [N-1:0]      sel_dvs;
    logic              sel_dbz;

    // Unpack the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign dvd_arr[gi] = req_dividend[gi*N +: N];
        assign dvs_arr[gi] = req_divisor[gi*N +: N];
    end

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign sel_dvd     = dvd_arr[grant_idx];
    assign sel_dvs     = dvs_arr[grant_idx];
    assign sel_dbz     = (sel_dvs[N-2:0] == '0);
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a complete seen in WAIT_HIGH beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = sel_dbz ? S_RESP : S_START;
                end
            end
            S_START:    state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (timeout_hit) begin
                    state_d = S_RESP;
                end else if (!div_complete) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (div_complete || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        div_start = (state_q == S_START);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
    end

    // Datapath: operand capture at grant, timeout counter, response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= IDW'(NREQ - 1);
            cnt_q          <= '0;
            rsp_id_q       <= '0;
            rsp_quotient_q <= '0;
            rsp_err_q      <= '0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        div_dividend_q <= sel_dvd;
                        div_divisor_q  <= sel_dvs;
                        ptr_q          <= grant_idx;
                        rsp_id_q       <= grant_idx;
                        if (sel_dbz) begin
                            rsp_quotient_q <= {sel_dvd[N-1] ^ sel_dvs[N-1], {(N-1){1'b1}}};
                            rsp_err_q      <= 2'b01;
                        end
                    end
                end
                S_START: cnt_q <= '0;
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    cnt_q <= cnt_inc;
                    if (state_q == S_WAIT_HIGH && div_complete) begin
                        rsp_quotient_q <= div_quotient;
                        rsp_err_q      <= 2'b00;
                    end else if (timeout_hit) begin
                        rsp_quotient_q <= '0;
                        rsp_err_q      <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id       = rsp_id_q;
    assign rsp_quotient = rsp_quotient_q;
    assign rsp_err      = rsp_err_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule
